// File: rtl/int_controller_pkg.sv
// Shared definitions for the interrupt controller: data width, register
// offsets within the bus window and the FSM state encoding (STATUS readback).
package int_controller_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [2:0] OFF_EN     = 3'd0;
  localparam logic [2:0] OFF_MASK   = 3'd1;
  localparam logic [2:0] OFF_PEND   = 3'd2;
  localparam logic [2:0] OFF_VEC    = 3'd3;
  localparam logic [2:0] OFF_CAUSE  = 3'd4;
  localparam logic [2:0] OFF_STATUS = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2,
    HOLD    = 2'd3
  } state_e;

  // Mask with the low n bits set; used to keep unimplemented source bits at 0.
  function automatic logic [DATA_W-1:0] src_bits(input int unsigned n);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/int_controller_if.sv
// Data-bus register window: address, write strobe/data and combinational read data.
interface int_controller_if;
  import int_controller_pkg::*;

  logic [7:0]        addr;
  logic [DATA_W-1:0] w_data;
  logic              w_en;
  logic [DATA_W-1:0] r_data;

  modport master (output addr, output w_data, output w_en, input r_data);
  modport slave  (input addr, input w_data, input w_en, output r_data);

endinterface

// File: rtl/int_priority_enc.sv
// Lowest-index-first priority encoder: returns the index of the lowest set bit.
module int_priority_enc #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] active,
  output logic [2:0]   idx,
  output logic         valid
);

  // Scan upward and latch the first set bit found.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (active[i] && !valid) begin
        valid = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/int_controller.sv
// Interrupt controller: edge-latches up to 8 sources into PEND, masks and
// prioritises them, issues a one-cycle int_req and then waits for a W1C
// acknowledge of the winning bit plus a short hold-off before re-arming.
module int_controller
  import int_controller_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter logic [7:0]  BASE    = 8'hF8,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_SRC-1:0]  src,
  int_controller_if.slave     bus,
  output logic                int_req,
  output logic [DATA_W-1:0]   int_en,
  output logic [DATA_W-1:0]   int_vec
);

  localparam logic [DATA_W-1:0] SRC_BITS = src_bits(NUM_SRC);
  localparam int unsigned       CNT_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;

  logic [DATA_W-1:0]  en_q, en_d;
  logic [DATA_W-1:0]  mask_q, mask_d;
  logic [DATA_W-1:0]  pend_q, pend_d;
  logic [DATA_W-1:0]  vec_q, vec_d;
  logic [2:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_SRC-1:0] src_prev_q;
  state_e             state_q, state_d;

  logic [8:0]        addr_ext;
  logic              in_win;
  logic [2:0]        off;
  logic              wr_en, wr_mask, wr_pend, wr_vec;
  logic [DATA_W-1:0] pend_clr;
  logic [DATA_W-1:0] rise;
  logic [DATA_W-1:0] active;
  logic [2:0]        win_idx;
  logic              win_valid;
  logic [DATA_W-1:0] rd;

  // 9-bit compare so a window near the top of the address space cannot wrap.
  assign addr_ext = {1'b0, bus.addr};
  assign in_win   = (addr_ext >= {1'b0, BASE}) && (addr_ext <= ({1'b0, BASE} + 9'd5));
  assign off      = 3'(bus.addr - BASE);
  assign wr_en    = bus.w_en && in_win;
  assign wr_mask  = wr_en && (off == OFF_MASK);
  assign wr_pend  = wr_en && (off == OFF_PEND);
  assign wr_vec   = wr_en && (off == OFF_VEC);

  assign rise   = SRC_BITS & DATA_W'(src & ~src_prev_q);
  assign active = pend_q & mask_q;

  int_priority_enc #(.N(DATA_W)) u_prio (
    .active (active),
    .idx    (win_idx),
    .valid  (win_valid)
  );

  // Register file updates and request/acknowledge FSM next-state.
  always_comb begin
    en_d     = en_q;
    mask_d   = mask_q;
    vec_d    = vec_q;
    cause_d  = cause_q;
    cnt_d    = cnt_q;
    state_d  = state_q;

    if (wr_en && (off == OFF_EN)) en_d = bus.w_data;
    if (wr_mask) mask_d = bus.w_data & SRC_BITS;
    if (wr_vec)  vec_d  = bus.w_data;

    // A new edge on a bit being cleared in the same cycle keeps it pending.
    pend_clr = wr_pend ? bus.w_data : '0;
    pend_d   = ((pend_q & ~pend_clr) | rise) & SRC_BITS;

    case (state_q)
      IDLE: begin
        if (en_q[0] && win_valid) begin
          state_d = REQ;
          cause_d = win_idx;
        end
      end
      REQ: begin
        state_d = en_q[0] ? SERVICE : IDLE;
      end
      SERVICE: begin
        if (wr_pend && bus.w_data[cause_q]) begin
          state_d = HOLD;
          cnt_d   = CNT_LOAD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset clears configuration, pending and the FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_q       <= '0;
      mask_q     <= '0;
      pend_q     <= '0;
      vec_q      <= '0;
      cause_q    <= '0;
      cnt_q      <= '0;
      src_prev_q <= '0;
      state_q    <= IDLE;
    end else begin
      en_q       <= en_d;
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      vec_q      <= vec_d;
      cause_q    <= cause_d;
      cnt_q      <= cnt_d;
      src_prev_q <= src;
      state_q    <= state_d;
    end
  end

  // Combinational read mux over the register window.
  always_comb begin
    rd = '0;
    if (in_win) begin
      case (off)
        OFF_EN:     rd = en_q;
        OFF_MASK:   rd = mask_q;
        OFF_PEND:   rd = pend_q;
        OFF_VEC:    rd = vec_q;
        OFF_CAUSE:  rd = DATA_W'(cause_q);
        OFF_STATUS: rd = DATA_W'(state_q);
        default:    rd = '0;
      endcase
    end
    bus.r_data = rd;
  end

  assign int_req = (state_q == REQ);
  assign int_en  = en_q;
  assign int_vec = vec_q;

endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: directed scenarios then random traffic, checked
// by a scoreboard fed from a behavioural model of the register/request rules.
module tb_int_controller;

  localparam int unsigned NUM_SRC = 4;
  localparam logic [7:0]  BASE    = 8'hF8;
  localparam int unsigned HOLDOFF = 2;
  localparam logic [7:0]  SRC_BITS = 8'((1 << NUM_SRC) - 1);

  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_SERV = 2;
  localparam int P_HOLD = 3;

  typedef struct {
    bit         chk;
    logic [7:0] rd;
    logic [7:0] en;
    logic [7:0] vec;
  } out_t;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [NUM_SRC-1:0] src   = '0;
  logic               int_req;
  logic [7:0]         int_en;
  logic [7:0]         int_vec;

  int_controller_if bus ();

  int_controller #(.NUM_SRC(NUM_SRC), .BASE(BASE), .HOLDOFF(HOLDOFF)) dut (
    .clock   (clock),
    .reset   (reset),
    .src     (src),
    .bus     (bus),
    .int_req (int_req),
    .int_en  (int_en),
    .int_vec (int_vec)
  );

  always #5 clock = ~clock;

  out_t out_q[$];
  int   req_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   run    = 1'b0;
  bit   done   = 1'b0;

  // Behavioural model state
  logic [7:0] m_en, m_mask, m_pend, m_vec, m_prev;
  int         m_cause, m_phase, m_left;

  function automatic void model_reset();
    m_en = 0; m_mask = 0; m_pend = 0; m_vec = 0; m_prev = 0;
    m_cause = 0; m_phase = P_IDLE; m_left = 0;
  endfunction

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a);
    int o;
    o = int'(a) - int'(BASE);
    case (o)
      0: return m_en;
      1: return m_mask;
      2: return m_pend;
      3: return m_vec;
      4: return 8'(m_cause);
      5: return 8'(m_phase);
      default: return 8'h00;
    endcase
  endfunction

  function automatic void model_step(input logic [7:0] s, input logic we,
                                     input logic [7:0] a, input logic [7:0] wd);
    int         o;
    bit         wr;
    logic [7:0] act;
    if (reset) begin
      model_reset();
      return;
    end
    o   = int'(a) - int'(BASE);
    wr  = we && (o >= 0) && (o <= 5);
    act = m_pend & m_mask;
    case (m_phase)
      P_IDLE: if (m_en[0] && act != 0) begin m_phase = P_REQ; m_cause = lowest(act); end
      P_REQ:  m_phase = m_en[0] ? P_SERV : P_IDLE;
      P_SERV: if (wr && o == 2 && wd[m_cause]) begin m_phase = P_HOLD; m_left = HOLDOFF - 1; end
      default: if (m_left == 0) m_phase = P_IDLE; else m_left--;
    endcase
    if (wr && o == 0) m_en = wd;
    if (wr && o == 1) m_mask = wd & SRC_BITS;
    if (wr && o == 3) m_vec = wd;
    m_pend = ((m_pend & ~((wr && o == 2) ? wd : 8'h00)) | (s & ~m_prev)) & SRC_BITS;
    m_prev = s;
  endfunction

  // One bus cycle: apply inputs, queue expected outputs, advance the model.
  // k >= 0 pins the expected read value to a constant instead of the model.
  task automatic step(input logic [7:0] s, input logic we, input logic [7:0] a,
                      input logic [7:0] wd, input int k);
    out_t e;
    src        = s[NUM_SRC-1:0];
    bus.addr   = a;
    bus.w_data = wd;
    bus.w_en   = we;
    e.chk = !we;
    e.rd  = (k >= 0) ? 8'(k) : model_read(a);
    e.en  = m_en;
    e.vec = m_vec;
    out_q.push_back(e);
    if (m_phase == P_REQ) req_q.push_back(cyc);
    @(posedge clock);
    model_step(s & SRC_BITS, we, a, wd);
    cyc++;
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clock) begin
    if (done) begin
      checks++;
      if (req_q.size() != 0 || out_q.size() != 0) begin
        errors++;
        $display("FAIL leftover_expect req_q=%0d out_q=%0d required 0", req_q.size(), out_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end else if (run) begin
      out_t e;
      if (out_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_queue_empty cyc=%0d", cyc);
      end else begin
        e = out_q.pop_front();
        if (e.chk) begin
          checks++;
          if (bus.r_data !== e.rd) begin
            errors++;
            $display("FAIL r_data cyc=%0d addr=%h got %h required %h", cyc, bus.addr, bus.r_data, e.rd);
          end
        end
        checks++;
        if (int_en !== e.en || int_vec !== e.vec) begin
          errors++;
          $display("FAIL en_vec cyc=%0d got %h/%h required %h/%h", cyc, int_en, int_vec, e.en, e.vec);
        end
      end
      while (req_q.size() > 0 && req_q[0] < cyc) begin
        checks++; errors++;
        $display("FAIL int_req_missing cyc=%0d got 0 required 1", req_q.pop_front());
      end
      if (int_req !== 1'b0) begin
        checks++;
        if (int_req === 1'b1 && req_q.size() > 0 && req_q[0] == cyc) begin
          void'(req_q.pop_front());
        end else begin
          errors++;
          $display("FAIL int_req_unexpected cyc=%0d got %b required 0", cyc, int_req);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] cs, d, a;
    int         r, o;
    model_reset();
    bus.addr = 8'h00; bus.w_data = 8'h00; bus.w_en = 1'b0;
    @(posedge clock); #1;
    run = 1'b1;
    // reset state, window reads while held and after release
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'hFD, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step(0, 0, 8'(BASE + 8'(i)), 0, 0);
    step(0, 0, 8'hF7, 0, 0);
    step(0, 0, 8'hFE, 0, 0);
    // basic request: EN=1, MASK=2, VEC=40, src[1] edge
    step(0, 1, 8'hF8, 8'h01, -1);
    step(0, 1, 8'hF9, 8'h02, -1);
    step(0, 1, 8'hFB, 8'h40, -1);
    step(8'h02, 0, 8'h00, 0, 0);
    step(0, 0, 8'hFA, 0, 8'h02);
    step(0, 0, 8'hFC, 0, 8'h01);
    step(0, 0, 8'hFD, 0, 8'h02);
    // edges during service, ack, hold-off, priority order
    step(0, 1, 8'hF9, 8'h07, -1);
    step(8'h05, 0, 8'h00, 0, 0);
    step(0, 0, 8'hFA, 0, 8'h07);
    step(0, 1, 8'hFA, 8'h02, -1);
    step(0, 0, 8'hFD, 0, 8'h03);
    step(0, 0, 8'hFD, 0, 8'h03);
    step(0, 0, 8'hFD, 0, 8'h00);
    step(0, 0, 8'hFC, 0, 8'h00);
    step(0, 0, 8'hFD, 0, 8'h02);
    step(0, 1, 8'hFA, 8'h01, -1);
    step(0, 0, 8'hFD, 0, 8'h03);
    step(0, 0, 8'hFD, 0, 8'h03);
    step(0, 0, 8'hFD, 0, 8'h00);
    step(0, 0, 8'hFC, 0, 8'h02);
    step(0, 0, 8'hFD, 0, 8'h02);
    step(0, 1, 8'hFA, 8'h04, -1);
    step(0, 0, 8'hFD, 0, 8'h03);
    step(0, 0, 8'hFD, 0, 8'h03);
    step(0, 0, 8'hFD, 0, 8'h00);
    // masked source, then unmask
    step(8'h08, 0, 8'h00, 0, 0);
    step(8'h08, 0, 8'hFA, 0, 8'h08);
    step(0, 0, 8'hFD, 0, 8'h00);
    step(0, 0, 8'hFD, 0, 8'h00);
    step(0, 1, 8'hF9, 8'h0F, -1);
    step(0, 0, 8'hFD, 0, 8'h00);
    step(0, 0, 8'hFC, 0, 8'h03);
    step(0, 1, 8'hFA, 8'h08, -1);
    step(0, 0, 8'hFD, 0, 8'h03);
    step(0, 0, 8'hFD, 0, 8'h03);
    step(0, 0, 8'hFD, 0, 8'h00);
    // same-cycle set and clear: set wins
    step(0, 1, 8'hF8, 8'h00, -1);
    step(8'h01, 1, 8'hFA, 8'h01, -1);
    step(8'h01, 0, 8'hFA, 0, 8'h01);
    step(0, 1, 8'hFA, 8'h01, -1);
    step(0, 0, 8'hFA, 0, 8'h00);
    step(0, 1, 8'hF8, 8'h01, -1);
    // reset during service
    step(8'h05, 0, 8'h00, 0, 0);
    step(0, 0, 8'hFA, 0, 8'h05);
    step(0, 0, 8'hFC, 0, 8'h00);
    step(0, 0, 8'hFA, 0, 8'h05);
    step(0, 0, 8'hFD, 0, 8'h02);
    reset = 1'b1; model_reset();
    step(0, 0, 8'hFD, 0, 8'h00);
    step(0, 0, 8'hFA, 0, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step(0, 0, 8'hFD, 0, 8'h00);
    // random traffic
    step(0, 1, 8'hF8, 8'h01, -1);
    step(0, 1, 8'hF9, 8'h0F, -1);
    cs = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NUM_SRC; b++) if ($urandom_range(5) == 0) cs[b] = ~cs[b];
      r = int'($urandom_range(99));
      if (r == 0) begin
        reset = 1'b1; model_reset();
        step(cs, 0, 8'hFD, 0, -1);
        reset = 1'b0;
        step(cs, 1, 8'hF8, 8'h01, -1);
        step(cs, 1, 8'hF9, 8'(SRC_BITS), -1);
      end else if (r < 22) begin
        o = int'($urandom_range(9));
        o = (o >= 6) ? 2 : o;
        d = 8'($urandom);
        if (o == 0) d[0] = ($urandom_range(4) != 0);
        step(cs, 1, 8'(BASE + 8'(o)), d, -1);
      end else begin
        a = 8'(int'(BASE) - 2 + int'($urandom_range(9)));
        step(cs, 0, a, 0, -1);
      end
    end
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0, -1);
    done = 1'b1;
  end

endmodule
